// File: rtl/emitter_uart_pkg.sv
// Shared frame constants and state type for the emitter_uart transmitter.
package emitter_uart_pkg;

    localparam int   FRAME_BITS  = 10;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // Wide enough to hold FRAME_BITS itself as the remaining-bit count.
    localparam int   BIT_CNT_W   = $clog2(FRAME_BITS + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        SENDING = 1'b1
    } tx_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: one-cycle tick every DIV enabled cycles, held at zero when disabled.
module baud_tick_gen #(
    parameter int DIV = 8
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_enable,
    output logic o_tick
);

    localparam int              CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (!i_resetn || !i_enable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tick = i_enable && (cnt == LAST);

endmodule

// File: rtl/emitter_uart.sv
// 8N1 UART transmitter with a ready/valid byte interface and a registered serial line.
//   state   | meaning
//   IDLE    | no bits left to send; line high, o_ready=1, next valid byte is accepted
//   SENDING | frame in flight; i_valid ignored, line advances one bit per baud tick
module emitter_uart
    import emitter_uart_pkg::*;
#(
    parameter int clk_freq_hz = 100000000,
    parameter int baud_rate   = 1000000
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_uart_tx
);

    localparam int DIV = clk_freq_hz / baud_rate;

    if (DIV < 2) begin : g_div_check
        $error("emitter_uart: clk_freq_hz / baud_rate must be at least 2");
    end

    tx_state_e            state;
    logic                 tick;
    logic                 accept;
    logic                 tx_q,        tx_d;
    logic [8:0]           shreg_q,     shreg_d;
    logic [BIT_CNT_W-1:0] bits_left_q, bits_left_d;

    assign state  = (bits_left_q == '0) ? IDLE : SENDING;
    assign accept = (state == IDLE) && i_valid;

    baud_tick_gen #(
        .DIV (DIV)
    ) u_baud_tick_gen (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_enable (state == SENDING),
        .o_tick   (tick)
    );

    // Start bit goes straight to the line; stop bit rides at the top of the shifter,
    // and idle level is shifted in behind it so the last tick leaves the line high.
    always_comb begin
        tx_d        = tx_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        if (accept) begin
            tx_d        = START_LEVEL;
            shreg_d     = {STOP_LEVEL, i_data};
            bits_left_d = BIT_CNT_W'(FRAME_BITS);
        end else if (tick) begin
            tx_d        = shreg_q[0];
            shreg_d     = {IDLE_LEVEL, shreg_q[8:1]};
            bits_left_d = bits_left_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            tx_q        <= IDLE_LEVEL;
            shreg_q     <= '0;
            bits_left_q <= '0;
        end else begin
            tx_q        <= tx_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
        end
    end

    assign o_ready   = (state == IDLE);
    assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_emitter_uart.sv
// Directed bench for emitter_uart at DIV=8, DIV=150 and truncated DIV=3.
module tb_emitter_uart;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] data;
    logic [2:0] valid;
    logic [2:0] rdy;
    logic [2:0] tx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    emitter_uart #(.clk_freq_hz(8), .baud_rate(1)) u_dut8 (
        .i_clk(clk), .i_resetn(resetn), .i_data(data), .i_valid(valid[0]),
        .o_ready(rdy[0]), .o_uart_tx(tx[0])
    );

    emitter_uart #(.clk_freq_hz(150000000), .baud_rate(1000000)) u_dut150 (
        .i_clk(clk), .i_resetn(resetn), .i_data(data), .i_valid(valid[1]),
        .o_ready(rdy[1]), .o_uart_tx(tx[1])
    );

    emitter_uart #(.clk_freq_hz(10), .baud_rate(3)) u_dut3 (
        .i_clk(clk), .i_resetn(resetn), .i_data(data), .i_valid(valid[2]),
        .o_ready(rdy[2]), .o_uart_tx(tx[2])
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Caller has i_valid/i_data set up before the accept edge. Samples every negedge
    // from the cycle after acceptance through the cycle o_ready returns.
    task automatic run_frame(input int sel, input logic [7:0] d, input int div,
                             input int pulse_k, input bit hold, input logic [7:0] next_d);
        logic [9:0] fr;
        int         low_cnt;
        fr      = {1'b1, d, 1'b0};
        low_cnt = 0;
        @(posedge clk);
        for (int k = 0; k <= 10 * div; k++) begin
            @(negedge clk);
            if (k < 10 * div) begin
                check($sformatf("tx%0d_k%0d", sel, k), 32'(tx[sel]), 32'(fr[k / div]));
                check($sformatf("rdy%0d_k%0d", sel, k), 32'(rdy[sel]), 32'd0);
                if (rdy[sel] === 1'b0) low_cnt++;
            end else begin
                check($sformatf("tx%0d_end", sel), 32'(tx[sel]), 32'd1);
                check($sformatf("rdy%0d_end", sel), 32'(rdy[sel]), 32'd1);
            end
            if (k == 0) begin
                if (hold) data = next_d;
                else valid[sel] = 1'b0;
            end
            if (k == pulse_k) begin
                valid[sel] = 1'b1;
                data       = 8'hA3;
            end
            if (k == pulse_k + 1) valid[sel] = 1'b0;
        end
        check($sformatf("low_cycles%0d", sel), 32'(low_cnt), 32'(10 * div));
    endtask

    initial begin
        resetn = 1'b0;
        data   = 8'h00;
        valid  = 3'b000;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst_tx%0d", s), 32'(tx[s]), 32'd1);
            check($sformatf("rst_rdy%0d", s), 32'(rdy[s]), 32'd1);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // 0x55 at DIV=8
        data = 8'h55; valid[0] = 1'b1;
        run_frame(0, 8'h55, 8, -10, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        // 0x00 then 0xFF with i_valid held across the boundary
        data = 8'h00; valid[0] = 1'b1;
        run_frame(0, 8'h00, 8, -10, 1'b1, 8'hFF);
        run_frame(0, 8'hFF, 8, -10, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        // 0xA3 pulse mid-frame must be ignored
        data = 8'h3C; valid[0] = 1'b1;
        run_frame(0, 8'h3C, 8, 37, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        // Reset in the middle of data bit 3 (frame bit 4)
        data = 8'h00; valid[0] = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            valid[0] = 1'b0;
        end
        check("pre_rst_tx", 32'(tx[0]), 32'd0);
        resetn = 1'b0; valid[0] = 1'b1;
        @(negedge clk);
        check("abort_tx", 32'(tx[0]), 32'd1);
        check("abort_rdy", 32'(rdy[0]), 32'd1);
        @(negedge clk);
        check("rst_valid_ign_tx", 32'(tx[0]), 32'd1);
        check("rst_valid_ign_rdy", 32'(rdy[0]), 32'd1);
        valid[0] = 1'b0; resetn = 1'b1;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_tx_k%0d", k), 32'(tx[0]), 32'd1);
            check($sformatf("post_rst_rdy_k%0d", k), 32'(rdy[0]), 32'd1);
        end

        // DIV=150
        data = 8'hC5; valid[1] = 1'b1;
        run_frame(1, 8'hC5, 150, -10, 1'b0, 8'h00);
        repeat (2) @(negedge clk);

        // DIV=3 (10/3 truncated)
        data = 8'h96; valid[2] = 1'b1;
        run_frame(2, 8'h96, 3, -10, 1'b0, 8'h00);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/emitter_uart.md
EMITTER_UART -- requirements
Module: emitter_uart

Interface
REQ-001: Parameter clk_freq_hz, default 100000000, is the input clock frequency in Hz.
REQ-002: Parameter baud_rate, default 1000000, is the serial bit rate in bits per second.
REQ-003: Port i_clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004: Port i_resetn, input, 1 bit: reset, synchronous and active-low.
REQ-005: Port i_data, input, 8 bits: byte to transmit.
REQ-006: Port i_valid, input, 1 bit: a byte is offered on i_data.
REQ-007: Port o_ready, output, 1 bit: the transmitter is idle and can accept a byte; the system reads its inverse as the "busy" status.
REQ-008: Port o_uart_tx, output, 1 bit: serial line, idle high.

Function
REQ-009: DIV SHALL be clk_freq_hz / baud_rate, using truncating integer division; each serial bit SHALL last exactly DIV clock cycles.
REQ-010: DIV shall be at least 2; elaboration SHALL fail with an error otherwise.
REQ-011: A byte SHALL be accepted on a rising edge where i_valid=1 and o_ready=1; i_data SHALL be sampled only at that edge.
REQ-012: Frame format SHALL be 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1): 10 bits, 10*DIV cycles in total.
REQ-013: In the cycle after acceptance, o_ready SHALL be 0 and o_uart_tx SHALL drive the start bit.
REQ-014: o_uart_tx SHALL change value only at bit boundaries; it SHALL be registered and free of glitches.
REQ-015: o_ready SHALL return to 1 exactly 10*DIV cycles after the acceptance edge, at the end of the stop bit; o_uart_tx SHALL remain 1 from then on.
REQ-016: While o_ready=0, i_valid SHALL be ignored and i_data changes SHALL have no effect on the frame in flight.
REQ-017: If i_valid is held at 1 when o_ready rises, the next byte SHALL be accepted at that edge, giving back-to-back frames with no extra idle bits.
REQ-018: When idle, o_uart_tx SHALL be 1 and o_ready SHALL be 1.
REQ-019: The bit-period counter SHALL be $clog2(DIV) bits wide and SHALL wrap to 0 at DIV-1; a bit index or shift-register count SHALL track the 10 frame bits.

Reset
REQ-020: When i_resetn=0 at a rising edge: o_uart_tx SHALL become 1, o_ready SHALL become 1, and all counters and the shift register SHALL clear.
REQ-021: A reset during a frame SHALL abort that frame immediately, with the line high on the next cycle; no partial bits SHALL resume after reset is released.
REQ-022: While i_resetn=0, i_valid SHALL be ignored.

Structure
REQ-023: A shared package SHALL hold FRAME_BITS=10, START_LEVEL=0, STOP_LEVEL=1 and IDLE_LEVEL=1.
REQ-024: One sub-module, baud_tick_gen, SHALL take i_clk, i_resetn and an enable, and SHALL produce a one-cycle tick every DIV cycles; the emitter SHALL shift on each tick.
REQ-025: The state SHALL be two-valued only, IDLE or SENDING, derived from the remaining-bit count being zero or non-zero.

Verification
REQ-026: Use clk_freq_hz=8, baud_rate=1 (DIV=8). Send 0x55 -> line holds 0,1,0,1,0,1,0,1,0,1, each for 8 cycles; o_ready stays low for 80 cycles and rises at cycle 80.
REQ-027: Send 0x00, then hold i_valid=1 with 0xFF -> the second frame starts the cycle o_ready rises; its start bit is 0 and its 8 data bits plus stop bit are 1.
REQ-028: Pulse i_valid with 0xA3 during a busy frame -> the pulse is ignored; only the original frame appears, and o_ready timing is unchanged.
REQ-029: Assert i_resetn=0 at bit 4 of a frame -> o_uart_tx=1 and o_ready=1 on the next cycle; the line stays high after release.
REQ-030: Use clk_freq_hz=150000000, baud_rate=1000000 -> DIV=150; o_ready is low for exactly 1500 cycles per byte.
REQ-031: Use clk_freq_hz=10, baud_rate=3 -> DIV=3 (truncated); each bit lasts 3 cycles.
